seq101_tx: RTL and testbench

SEQ101_TX -- requirements
Module: seq101_tx

---
 rtl/seq101_pkg.sv | 28 ++
 rtl/piso_shift.sv | 32 +++
 rtl/seq101_tx.sv | 117 +++++++++++
 tb/tb_seq101_tx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq101_pkg.sv
// seq101_pkg: state encoding and preamble constants shared by the 101 transmitter and detector bench.
// Revision 1.0
`default_nettype none

package seq101_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PRE  = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    localparam logic [2:0] PREAMBLE = 3'b101;
    localparam int         PRE_LEN  = 3;

    // Counter must index the longest phase: max(PRE_LEN, data_w, gap_bits) positions.
    function automatic int cnt_width(input int data_w, input int gap_bits);
        int m;
        m = PRE_LEN;
        if (data_w > m)   m = data_w;
        if (gap_bits > m) m = gap_bits;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift.sv
// piso_shift: parallel-load, shift-left register presenting its MSB as the serial bit.
// Revision 1.0
`default_nettype none

module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= din_i;
        end else if (shift_i) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

`default_nettype wire

// File: rtl/seq101_tx.sv
// seq101_tx: frames a payload word as preamble 101, MSB-first data, then idle-zero gap bits.
// Revision 1.0
`default_nettype none

module seq101_tx
    import seq101_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = cnt_width(DATA_W, GAP_BITS);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             shift_en;
    logic             sr_msb;
    logic [1:0]       pre_idx;

    assign accept = (state_q == ST_IDLE) && din_valid;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (din_valid) begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                end
            end
            ST_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                shift_en = 1'b1;
                if (cnt_q == DATA_LAST) begin
                    state_d = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shift #(.W(DATA_W)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (shift_en),
        .din_i   (din),
        .msb_o   (sr_msb)
    );

    // Preamble is emitted from its MSB down as the counter advances.
    assign pre_idx = 2'(PRE_LEN - 1) - cnt_q[1:0];

    always_comb begin
        sout = 1'b0;
        case (state_q)
            ST_PRE:  sout = PREAMBLE[pre_idx];
            ST_DATA: sout = sr_msb;
            default: sout = 1'b0;
        endcase
    end

    assign din_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = ((state_q == ST_GAP) && (cnt_q == GAP_LAST)) ||
                       ((GAP_BITS == 0) && (state_q == ST_DATA) && (cnt_q == DATA_LAST));

endmodule

`default_nettype wire

// File: tb/tb_seq101_tx.sv
// tb_seq101_tx: table-driven check of seq101_tx framing plus hand sequences for loopback and zero-gap.
// Revision 1.0
`default_nettype none

module tb_seq101_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready, sout, busy, done;

    logic       rst_b = 1'b0;
    logic [3:0] din_b = 4'h0;
    logic       din_valid_b = 1'b0;
    logic       din_ready_b, sout_b, busy_b, done_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seq101_tx #(.DATA_W(8), .GAP_BITS(2)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .sout(sout), .busy(busy), .done(done)
    );

    seq101_tx #(.DATA_W(4), .GAP_BITS(0)) dut_b (
        .clk(clk), .rst(rst_b), .din(din_b), .din_valid(din_valid_b),
        .din_ready(din_ready_b), .sout(sout_b), .busy(busy_b), .done(done_b)
    );

    // exp packs {sout, din_ready, busy, done} after the edge that consumes the inputs.
    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic [3:0] exp;
    } vec_t;

    vec_t vq[$];
    localparam logic [3:0] IDLE_E = 4'b0100;

    task automatic add(input logic r, input logic v, input logic [7:0] d, input logic [3:0] e);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.exp = e;
        vq.push_back(x);
    endtask

    // One full 13-cycle frame; bits is the hand-computed sout stream, first bit in the MSB.
    task automatic add_frame(input logic [7:0] d0, input logic vr, input logic [7:0] dr,
                             input logic churn, input logic [12:0] bits);
        logic [12:0] b;
        logic        v;
        logic [7:0]  d;
        b = bits;
        for (int i = 0; i < 13; i++) begin
            if (i == 0) begin
                v = 1'b1; d = d0;
            end else if (churn) begin
                v = 1'($urandom_range(0, 1)); d = 8'($urandom);
            end else begin
                v = vr; d = dr;
            end
            add(1'b1, v, d, {b[12-i], 1'b0, 1'b1, (i == 12)});
        end
    endtask

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got {sout,rdy,busy,done}=%b want %b", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    initial begin
        logic [2:0] hist;
        int         ndet;
        int         det_at[2];
        logic [6:0] bexp;

        // Reset, including valid offered during reset
        add(1'b0, 1'b0, 8'h00, IDLE_E);
        add(1'b0, 1'b1, 8'hFF, IDLE_E);
        add(1'b1, 1'b0, 8'h00, IDLE_E);
        // Single frame A5
        add_frame(8'hA5, 1'b0, 8'h00, 1'b0, 13'b101_10100101_00);
        add(1'b1, 1'b0, 8'h00, IDLE_E);
        // Back-to-back FF then 00 held valid
        add_frame(8'hFF, 1'b1, 8'h00, 1'b0, 13'b101_11111111_00);
        add(1'b1, 1'b1, 8'h00, IDLE_E);
        add_frame(8'h00, 1'b0, 8'h00, 1'b0, 13'b101_00000000_00);
        add(1'b1, 1'b0, 8'h00, IDLE_E);
        // Mid-frame reset during 3C data bit 4, valid asserted with reset
        add(1'b1, 1'b1, 8'h3C, 4'b1010);
        add(1'b1, 1'b0, 8'h00, 4'b0010);
        add(1'b1, 1'b0, 8'h00, 4'b1010);
        add(1'b1, 1'b0, 8'h00, 4'b0010);
        add(1'b1, 1'b0, 8'h00, 4'b0010);
        add(1'b1, 1'b0, 8'h00, 4'b1010);
        add(1'b1, 1'b0, 8'h00, 4'b1010);
        add(1'b1, 1'b0, 8'h00, 4'b1010);
        add(1'b0, 1'b1, 8'hFF, IDLE_E);
        add(1'b1, 1'b0, 8'h00, IDLE_E);
        add_frame(8'h81, 1'b0, 8'h00, 1'b0, 13'b101_10000001_00);
        add(1'b1, 1'b0, 8'h00, IDLE_E);
        // Input churn while busy
        add_frame(8'h5A, 1'b0, 8'h00, 1'b1, 13'b101_01011010_00);
        add(1'b1, 1'b0, 8'h00, IDLE_E);

        for (int i = 0; i < vq.size(); i++) begin
            rst       = vq[i].r;
            din_valid = vq[i].v;
            din       = vq[i].d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {sout, din_ready, busy, done}, vq[i].exp);
        end

        // Loopback into a 101 detector model: two back-to-back 00 frames.
        hist = 3'b000;
        ndet = 0;
        det_at[0] = -1;
        det_at[1] = -1;
        din_valid = 1'b1;
        din = 8'h00;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 15) din_valid = 1'b0;
            // Detector output is registered: a 101 ending in cycle k reports in cycle k+1.
            hist = {hist[1:0], sout};
            if (hist == 3'b101) begin
                if (ndet < 2) det_at[ndet] = k + 1;
                ndet++;
            end
        end
        check_int("loop_count", ndet, 2);
        check_int("loop_det0", det_at[0], 4);
        check_int("loop_det1", det_at[1], 18);

        // Zero-gap instance: DATA_W=4, din=9 -> 1,0,1,1,0,0,1
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check("b_reset", {sout_b, din_ready_b, busy_b, done_b}, IDLE_E);
        rst_b = 1'b1;
        din_valid_b = 1'b1;
        din_b = 4'h9;
        bexp = 7'b101_1001;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            din_b = 4'h6;
            check($sformatf("b_cyc%0d", i + 1), {sout_b, din_ready_b, busy_b, done_b},
                  {bexp[6-i], 1'b0, 1'b1, (i == 6)});
        end
        @(posedge clk);
        #1;
        check("b_idle", {sout_b, din_ready_b, busy_b, done_b}, IDLE_E);
        @(posedge clk);
        #1;
        check("b_next_pre", {sout_b, din_ready_b, busy_b, done_b}, 4'b1010);
        din_valid_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
